// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, debounce FSM and one-cycle edge pulses
// for raw board inputs (switches, buttons, proximity io) feeding the core's input drivers.
// Optional build macro INCOND_STICKY_EN adds per-channel sticky press flags
// (sticky_clr / sticky_out) so software polling cannot miss short presses.
module input_conditioner #(
    parameter int unsigned       N_CH            = 6,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter logic [N_CH-1:0]   RESET_VAL       = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_CH-1:0] raw_in,
`ifdef INCOND_STICKY_EN
    input  logic [N_CH-1:0] sticky_clr,
    output logic [N_CH-1:0] sticky_out,
`endif
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle hold the stable states accept immediately, skipping the check states.
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   sync_lvl;
        state_t                 state_r;
        logic [CNT_W-1:0]       cnt_r;
        logic                   clean_r;
        logic                   rise_r;
        logic                   fall_r;

        assign sync_lvl = sync_r[SYNC_STAGES-1];

        // Metastability synchroniser; reset level matches the channel's reset value.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync_r <= {SYNC_STAGES{RESET_VAL[i]}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        // Debounce FSM: a new level must be seen DEBOUNCE_CYCLES times in a row to be accepted.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_r <= RESET_VAL[i] ? STABLE_HI : STABLE_LO;
                cnt_r   <= '0;
                clean_r <= RESET_VAL[i];
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                case (state_r)
                    STABLE_LO: begin
                        if (sync_lvl) begin
                            if (SINGLE) begin
                                state_r <= STABLE_HI;
                                cnt_r   <= '0;
                                clean_r <= 1'b1;
                                rise_r  <= 1'b1;
                            end else begin
                                state_r <= CHK_HI;
                                cnt_r   <= CNT_ONE;
                            end
                        end else begin
                            cnt_r <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!sync_lvl) begin
                            state_r <= STABLE_LO;
                            cnt_r   <= '0;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= STABLE_HI;
                            cnt_r   <= '0;
                            clean_r <= 1'b1;
                            rise_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync_lvl) begin
                            if (SINGLE) begin
                                state_r <= STABLE_LO;
                                cnt_r   <= '0;
                                clean_r <= 1'b0;
                                fall_r  <= 1'b1;
                            end else begin
                                state_r <= CHK_LO;
                                cnt_r   <= CNT_ONE;
                            end
                        end else begin
                            cnt_r <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (sync_lvl) begin
                            state_r <= STABLE_HI;
                            cnt_r   <= '0;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= STABLE_LO;
                            cnt_r   <= '0;
                            clean_r <= 1'b0;
                            fall_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                endcase
            end
        end

        assign clean_out[i]  = clean_r;
        assign rise_pulse[i] = rise_r;
        assign fall_pulse[i] = fall_r;

`ifdef INCOND_STICKY_EN
        logic sticky_r;
        logic accept_hi_c;

        // High exactly when the FSM will register a rising accept at this edge.
        assign accept_hi_c = sync_lvl &&
                             (((state_r == STABLE_LO) && SINGLE) ||
                              ((state_r == CHK_HI) && (cnt_r == CNT_LAST)));

        // Sticky press flag; a coincident set beats the clear.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sticky_r <= 1'b0;
            end else if (accept_hi_c) begin
                sticky_r <= 1'b1;
            end else if (sticky_clr[i]) begin
                sticky_r <= 1'b0;
            end
        end

        assign sticky_out[i] = sticky_r;
`endif
    end

endmodule
